// File: rtl/if_fetch.sv
// if_fetch: pipelined instruction fetch with an in-order response buffer and jump flush
module if_fetch #(
  parameter int DEPTH = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        i_Clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_addr,
  input  logic        i_jump_flag,
  output logic        o_pc_hold,
  output logic        o_req_valid,
  output logic [31:0] o_req_addr,
  input  logic        i_req_ready,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_addr,
  input  logic        i_id_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0] wr_q, fill_q, rd_q;
  logic [CW-1:0] alloc_q, pend_q, drop_q, drop_d, owed;
  logic fire, drop_rsp, fill, consume;
  always_comb begin
    o_req_addr = {i_pc_addr[31:2], 2'b00};
    o_req_valid = ~i_reset & ~i_jump_flag & (alloc_q + drop_q < CW'(DEPTH));
    fire = o_req_valid & i_req_ready;
    o_pc_hold = ~fire;
    drop_rsp = i_rsp_valid & (drop_q != '0);
    fill = i_rsp_valid & (drop_q == '0) & (pend_q != '0);
    o_inst_valid = filled_q[rd_q] & (alloc_q != '0) & ~i_jump_flag;
    consume = o_inst_valid & i_id_ready;
    o_inst = o_inst_valid ? data_q[rd_q] : NOP_INST;
    o_inst_addr = o_inst_valid ? addr_q[rd_q] : '0;
    // every in-flight request of a flushed stream is still owed a response
    owed = drop_q + pend_q;
    drop_d = (i_rsp_valid && owed != '0) ? owed - CW'(1) : owed;
  end
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      filled_q <= '0;
      wr_q <= '0;
      fill_q <= '0;
      rd_q <= '0;
      alloc_q <= '0;
      pend_q <= '0;
      drop_q <= '0;
    end else if (i_jump_flag) begin
      filled_q <= '0;
      fill_q <= wr_q;
      rd_q <= wr_q;
      alloc_q <= '0;
      pend_q <= '0;
      drop_q <= drop_d;
    end else begin
      if (fire) begin
        addr_q[wr_q] <= o_req_addr;
        filled_q[wr_q] <= 1'b0;
        wr_q <= wr_q + PW'(1);
      end
      if (fill) begin
        data_q[fill_q] <= i_rsp_data;
        filled_q[fill_q] <= 1'b1;
        fill_q <= fill_q + PW'(1);
      end
      if (consume) begin
        filled_q[rd_q] <= 1'b0;
        rd_q <= rd_q + PW'(1);
      end
      alloc_q <= alloc_q + CW'(fire) - CW'(consume);
      pend_q <= pend_q + CW'(fire) - CW'(fill);
      drop_q <= drop_q - CW'(drop_rsp);
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: queue-level fetch model, memory and PC environment, directed scenarios
module tb_if_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, i_reset = 1, i_jump_flag = 0, i_req_ready = 1, i_rsp_valid = 0, i_id_ready = 1;
  logic [31:0] i_pc_addr = 0, i_rsp_data = 0;
  logic o_pc_hold, o_req_valid, o_inst_valid;
  logic [31:0] o_req_addr, o_inst, o_inst_addr;
  always #5 clk = ~clk;
  if_fetch #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .i_Clk(clk), .i_reset(i_reset), .i_pc_addr(i_pc_addr), .i_jump_flag(i_jump_flag),
    .o_pc_hold(o_pc_hold), .o_req_valid(o_req_valid), .o_req_addr(o_req_addr),
    .i_req_ready(i_req_ready), .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_addr(o_inst_addr), .i_id_ready(i_id_ready)
  );
  typedef struct {logic [31:0] addr; logic [31:0] data; bit filled;} ent_t;
  typedef struct {logic [31:0] addr; int cyc; logic [31:0] data;} ev_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  ent_t fq[$];
  ev_t fired[$], dlv[$];
  mreq_t mq[$];
  int drop = 0, n_cmp = 0, n_bad = 0, cyc = 0, lat = 1, n;
  bit started = 0, mem_en = 1, rsp_v_nxt = 0;
  logic [31:0] pc_nxt = 0, jt = 0, rsp_d_nxt = 0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction
  function automatic logic [31:0] faddr(input int i);
    return i < fired.size() ? fired[i].addr : 32'hFFFFFFFF;
  endfunction
  function automatic logic [31:0] daddr(input int i);
    return i < dlv.size() ? dlv[i].addr : 32'hFFFFFFFF;
  endfunction
  function automatic logic [31:0] ddata(input int i);
    return i < dlv.size() ? dlv[i].data : 32'hFFFFFFFF;
  endfunction
  function automatic int dcyc(input int i);
    return i < dlv.size() ? dlv[i].cyc : -100;
  endfunction
  function automatic int fcyc(input int i);
    return i < fired.size() ? fired[i].cyc : 100;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // model, memory and PC run at the negedge, looking at the inputs the next posedge will sample
  always @(negedge clk) begin
    bit erv, eiv, efire;
    int unf, d;
    erv = !i_reset && !i_jump_flag && (fq.size() + drop < DEPTH);
    eiv = !i_jump_flag && fq.size() > 0 && fq[0].filled;
    efire = erv && i_req_ready;
    if (started) begin
      chk("req_valid", o_req_valid, erv);
      chk("pc_hold", o_pc_hold, !efire);
      chk("req_addr", o_req_addr, {i_pc_addr[31:2], 2'b00});
      chk("inst_valid", o_inst_valid, eiv);
      chk("inst", o_inst, eiv ? fq[0].data : NOP);
      chk("inst_addr", o_inst_addr, eiv ? fq[0].addr : 32'h0);
    end
    if (o_req_valid && i_req_ready) begin
      fired.push_back('{o_req_addr, cyc, 32'h0});
      mq.push_back('{o_req_addr, cyc + lat});
    end
    if (o_inst_valid && i_id_ready) dlv.push_back('{o_inst_addr, cyc, o_inst});
    if (i_reset) begin
      fq.delete();
      drop = 0;
    end else if (i_jump_flag) begin
      unf = 0;
      foreach (fq[i]) if (!fq[i].filled) unf++;
      d = drop + unf - (i_rsp_valid ? 1 : 0);
      drop = d < 0 ? 0 : d;
      fq.delete();
    end else begin
      if (i_rsp_valid) begin
        if (drop > 0) drop--;
        else
          for (int i = 0; i < fq.size(); i++)
            if (!fq[i].filled) begin
              fq[i].filled = 1;
              fq[i].data = i_rsp_data;
              break;
            end
      end
      if (eiv && i_id_ready) void'(fq.pop_front());
      if (efire) fq.push_back('{{i_pc_addr[31:2], 2'b00}, 32'h0, 1'b0});
    end
    pc_nxt = i_reset ? 32'h0 : i_jump_flag ? jt : o_pc_hold ? i_pc_addr : i_pc_addr + 32'd4;
    rsp_v_nxt = 0;
    rsp_d_nxt = 0;
    if (mem_en && mq.size() > 0 && mq[0].due <= cyc + 1) begin
      rsp_v_nxt = 1;
      rsp_d_nxt = f(mq[0].addr);
      void'(mq.pop_front());
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    i_pc_addr = pc_nxt;
    i_rsp_valid = rsp_v_nxt;
    i_rsp_data = rsp_d_nxt;
  endtask
  task automatic do_reset(input int k);
    i_reset = 1;
    i_jump_flag = 0;
    i_req_ready = 1;
    i_id_ready = 1;
    mem_en = 1;
    lat = 1;
    repeat (k) tick();
    i_reset = 0;
    fired.delete();
    dlv.delete();
  endtask
  task automatic wait_dlv(input int k, input string nm);
    for (int j = 0; j < 30 && dlv.size() <= k; j++) tick();
    chk(nm, dlv.size() > k, 1);
  endtask

  initial begin
    tick();
    started = 1;
    #1;
    chk("rst_inst_valid", o_inst_valid, 0);
    chk("rst_inst", o_inst, 32'h00000013);
    chk("rst_inst_addr", o_inst_addr, 0);
    chk("rst_req_valid", o_req_valid, 0);
    chk("rst_hold", o_pc_hold, 1);
    do_reset(2);
    // streaming with latency 1
    repeat (10) tick();
    chk("t1_fire0", faddr(0), 32'h0);
    chk("t1_fire1", faddr(1), 32'h4);
    chk("t1_dlv0", daddr(0), 32'h0);
    chk("t1_dlv1", daddr(1), 32'h4);
    chk("t1_data0", ddata(0), 32'hC0DE0000);
    chk("t1_lat", dcyc(0) - fcyc(0), 2);
    // decode stall fills the queue
    do_reset(4);
    i_id_ready = 0;
    repeat (6) tick();
    #1;
    chk("t2_nfire", fired.size(), 2);
    chk("t2_req_valid", o_req_valid, 0);
    chk("t2_hold", o_pc_hold, 1);
    i_id_ready = 1;
    repeat (6) tick();
    chk("t2_dlv0", daddr(0), 32'h0);
    chk("t2_dlv1", daddr(1), 32'h4);
    chk("t2_fire2", faddr(2), 32'h8);
    // memory not ready
    do_reset(4);
    for (int k = 0; k < 40 && i_pc_addr != 32'h10; k++) tick();
    chk("t3_reach", i_pc_addr, 32'h10);
    i_req_ready = 0;
    repeat (3) begin
      #1;
      chk("t3_hold", o_pc_hold, 1);
      chk("t3_addr", o_req_addr, 32'h10);
      tick();
    end
    i_req_ready = 1;
    n = fired.size();
    for (int k = 0; k < 10 && fired.size() == n; k++) tick();
    chk("t3_fire", faddr(n), 32'h10);
    chk("t3_adv", i_pc_addr, 32'h14);
    repeat (4) tick();
    n = 0;
    foreach (fired[i]) if (fired[i].addr == 32'h10) n++;
    chk("t3_once", n, 1);
    // jump with two requests in flight
    do_reset(4);
    i_jump_flag = 1;
    jt = 32'h20;
    tick();
    i_jump_flag = 0;
    mem_en = 0;
    tick();
    tick();
    i_jump_flag = 1;
    jt = 32'h100;
    #1;
    chk("t4_jump_iv", o_inst_valid, 0);
    chk("t4_jump_rv", o_req_valid, 0);
    chk("t4_fire0", faddr(0), 32'h20);
    chk("t4_fire1", faddr(1), 32'h24);
    tick();
    i_jump_flag = 0;
    mem_en = 1;
    wait_dlv(0, "t4_timeout");
    chk("t4_dlv_addr", daddr(0), 32'h100);
    chk("t4_dlv_data", ddata(0), 32'hC0DE0100);
    // jump coinciding with the first response
    do_reset(4);
    lat = 2;
    i_jump_flag = 1;
    jt = 32'h20;
    tick();
    i_jump_flag = 0;
    tick();
    tick();
    i_jump_flag = 1;
    jt = 32'h100;
    #1;
    chk("t5_jump_iv", o_inst_valid, 0);
    chk("t5_fire1", faddr(1), 32'h24);
    tick();
    i_jump_flag = 0;
    wait_dlv(0, "t5_timeout");
    chk("t5_dlv_addr", daddr(0), 32'h100);
    chk("t5_dlv_data", ddata(0), 32'hC0DE0100);
    // reset with one entry filled and one in flight
    do_reset(4);
    i_id_ready = 0;
    tick();
    tick();
    mem_en = 0;
    tick();
    i_reset = 1;
    tick();
    mem_en = 1;
    #1;
    chk("t6_iv", o_inst_valid, 0);
    chk("t6_inst", o_inst, 32'h00000013);
    chk("t6_addr", o_inst_addr, 0);
    chk("t6_hold", o_pc_hold, 1);
    tick();
    i_reset = 0;
    i_id_ready = 1;
    fired.delete();
    dlv.delete();
    wait_dlv(0, "t6_timeout");
    chk("t6_fire0", faddr(0), 32'h0);
    chk("t6_dlv_addr", daddr(0), 32'h0);
    chk("t6_dlv_data", ddata(0), 32'hC0DE0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
